// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: SCAN-order elevator car controller for NUM_FLOORS floors.
// Optional emergency-stop input is enabled by defining ELEVATOR_ESTOP_EN.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS    = 8,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_req,
`ifdef ELEVATOR_ESTOP_EN
   input  logic                  estop,
`endif
   output logic [FLOOR_W-1:0]    current_floor,
   output logic [1:0]            direction,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
);

   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   state_t                state, state_n;
   logic [TW-1:0]         travel_cnt, travel_cnt_n;
   logic [DW-1:0]         door_cnt, door_cnt_n;
   logic                  dir_pref;
   logic                  stop;
   logic                  moving, arrive, hold;
   logic                  above, below, here;
   logic                  up_beyond, dn_beyond;
   logic [FLOOR_W-1:0]    next_floor, clr_floor;
   logic [NUM_FLOORS-1:0] req_all, clr, pending_n;

`ifdef ELEVATOR_ESTOP_EN
   assign stop = estop;
`else
   assign stop = 1'b0;
`endif

   assign moving     = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign arrive     = moving && (travel_cnt == TW'(TRAVEL_CYCLES - 1));
   assign next_floor = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                          : current_floor - FLOOR_W'(1);
   assign req_all    = pending | call_req;
   assign here       = pending[current_floor];
   assign hold       = (state == DOOR_OPEN) && call_req[current_floor] && !stop;

   // Locate pending calls relative to the car and to the arriving floor
   always_comb begin
      above     = 1'b0;
      below     = 1'b0;
      up_beyond = 1'b0;
      dn_beyond = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i > int'(current_floor))) above = 1'b1;
         if (pending[i] && (i < int'(current_floor))) below = 1'b1;
         if (req_all[i] && (i > int'(next_floor)))    up_beyond = 1'b1;
         if (req_all[i] && (i < int'(next_floor)))    dn_beyond = 1'b1;
      end
   end

   // Next-state selection in SCAN order
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (stop || here)                     state_n = DOOR_OPEN;
            else if (above && (dir_pref || !below)) state_n = MOVE_UP;
            else if (below)                       state_n = MOVE_DOWN;
         end
         MOVE_UP: begin
            if (arrive) begin
               if (stop || req_all[next_floor]) state_n = DOOR_OPEN;
               else if (up_beyond)              state_n = MOVE_UP;
               else                             state_n = IDLE;
            end
         end
         MOVE_DOWN: begin
            if (arrive) begin
               if (stop || req_all[next_floor]) state_n = DOOR_OPEN;
               else if (dn_beyond)              state_n = MOVE_DOWN;
               else                             state_n = IDLE;
            end
         end
         DOOR_OPEN: begin
            if (!stop && !hold && (door_cnt == DW'(DOOR_CYCLES - 1)))
               state_n = IDLE;
         end
      endcase
   end

   // Counters and request latch updates; the served floor is cleared on entry
   always_comb begin
      travel_cnt_n = '0;
      door_cnt_n   = '0;
      clr_floor    = arrive ? next_floor : current_floor;
      clr          = '0;
      if (moving && !arrive)
         travel_cnt_n = travel_cnt + TW'(1);
      if ((state == DOOR_OPEN) && (state_n == DOOR_OPEN) && !hold && !stop)
         door_cnt_n = door_cnt + DW'(1);
      if ((state == DOOR_OPEN) || (state_n == DOOR_OPEN))
         clr = NUM_FLOORS'(1) << clr_floor;
      pending_n = stop ? '0 : (req_all & ~clr);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         current_floor <= '0;
         travel_cnt    <= '0;
         door_cnt      <= '0;
         dir_pref      <= 1'b1;
         pending       <= '0;
      end else begin
         state      <= state_n;
         travel_cnt <= travel_cnt_n;
         door_cnt   <= door_cnt_n;
         pending    <= pending_n;
         if (arrive) begin
            current_floor <= next_floor;
            dir_pref      <= (state == MOVE_UP);
         end
      end
   end

   // Moore output decode
   always_comb begin
      direction = 2'b00;
      unique case (state)
         MOVE_UP:   direction = 2'b01;
         MOVE_DOWN: direction = 2'b10;
         default:   direction = 2'b00;
      endcase
   end

   assign door_open = (state == DOOR_OPEN);
   assign busy      = (state != IDLE) || (|pending);

endmodule
